spi_tx_feeder: RTL

Upstream stage of the SPI master. Buffers 12-bit words from a producer in a small synchronous FIFO. Presents one word at a time on din/newd, and holds newd until the master shows acceptance by driving cs low. Waits for the frame to end (cs high) plus a programmable idle gap before offering the next word. Counts completed frames and flags dropped writes.

---
 rtl/spi_tx_feeder_if.sv | 28 ++
 rtl/spi_tx_feeder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/spi_tx_feeder_if.sv
// Producer write port and SPI-master offer/acceptance signals of spi_tx_feeder.
// The slave modport is the feeder; the master modport is the producer plus the SPI master.
interface spi_tx_feeder_if #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
);
    logic                     wr_en;
    logic [WIDTH-1:0]         wr_data;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     newd;
    logic [WIDTH-1:0]         din;
    logic                     cs;
    logic                     busy;
    logic [15:0]              frames_sent;

    modport master (
        output wr_en, wr_data, cs,
        input  full, empty, count, overflow, newd, din, busy, frames_sent
    );

    modport slave (
        input  wr_en, wr_data, cs,
        output full, empty, count, overflow, newd, din, busy, frames_sent
    );
endinterface

// File: rtl/spi_tx_feeder.sv
// Buffers words in a FIFO and offers them one at a time to the SPI master, with an idle gap between frames.
// Latency: write to newd is 2 clk; a full FIFO drops the write and sets sticky overflow; newd is held until cs falls.
module spi_tx_feeder #(
    parameter int WIDTH      = 12,
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 4
) (
    input logic           clk,
    input logic           rst,
    spi_tx_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, OFFER, ACTIVE, GAP} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count_q, count_nxt;
    logic             full_q, empty_q, ovf_q;
    logic             cs_q1, cs_s, cs_s_prev;
    logic             cs_fall, cs_rise;
    logic             push, pop;
    logic             newd_q, newd_nxt;
    logic [WIDTH-1:0] din_q, din_nxt;
    logic [15:0]      frames_q, frames_nxt;
    logic [GW-1:0]    gap_q, gap_nxt;

    assign push    = bus.wr_en & ~full_q;
    assign cs_fall = cs_s_prev & ~cs_s;
    assign cs_rise = ~cs_s_prev & cs_s;

    // cs idles high, so the synchronizer resets to 1 to avoid a false edge after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q1     <= 1'b1;
            cs_s      <= 1'b1;
            cs_s_prev <= 1'b1;
        end else begin
            cs_q1     <= bus.cs;
            cs_s      <= cs_q1;
            cs_s_prev <= cs_s;
        end
    end

    always_comb begin
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_nxt;
            full_q  <= (count_nxt == DEPTH_C);
            empty_q <= (count_nxt == '0);
            if (bus.wr_en && full_q) ovf_q <= 1'b1;
        end
    end

    // The offered word stays in the FIFO until the master takes it (cs falls)
    always_comb begin
        state_nxt  = state;
        newd_nxt   = newd_q;
        din_nxt    = din_q;
        frames_nxt = frames_q;
        gap_nxt    = gap_q;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_q) begin
                    state_nxt = OFFER;
                    newd_nxt  = 1'b1;
                    din_nxt   = mem[rd_ptr];
                end
            end
            OFFER: begin
                if (cs_fall) begin
                    newd_nxt  = 1'b0;
                    pop       = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    frames_nxt = frames_q + 16'd1;
                    gap_nxt    = '0;
                    state_nxt  = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_nxt = IDLE;
                else                   gap_nxt   = gap_q + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            newd_q   <= 1'b0;
            din_q    <= '0;
            frames_q <= '0;
            gap_q    <= '0;
        end else begin
            state    <= state_nxt;
            newd_q   <= newd_nxt;
            din_q    <= din_nxt;
            frames_q <= frames_nxt;
            gap_q    <= gap_nxt;
        end
    end

    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.count       = count_q;
    assign bus.overflow    = ovf_q;
    assign bus.newd        = newd_q;
    assign bus.din         = din_q;
    assign bus.busy        = (state != IDLE);
    assign bus.frames_sent = frames_q;
endmodule
